// File: rtl/decode_stage.sv
// Instruction-decode stage: IF/ID pipeline register, 32-entry register file
// with write-through bypass, and pure-slice field decode of the latched word.
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [31:0]       if_instr,
  input  logic [31:0]       if_pc_plus4,
  input  logic              if_valid,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_valid,
  output logic [31:0]       id_pc_plus4,
  output logic [5:0]        id_opcode,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic [4:0]        id_rd,
  output logic [4:0]        id_shamt,
  output logic [5:0]        id_funct,
  output logic [15:0]       id_imm16,
  output logic [25:0]       id_jtarget,
  output logic [DATA_W-1:0] id_rs_data,
  output logic [DATA_W-1:0] id_rt_data
);

  logic [31:0]       instr_q, instr_d;
  logic [31:0]       pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rf_q [NREGS];
  logic              wb_write;

  // Register 0 is hard-wired to zero, so writes aimed at it never land.
  assign wb_write = wb_we && (wb_addr != 5'd0) && (int'(wb_addr) < NREGS);

  // IF/ID next-state: flush beats stall, stall beats load.
  always_comb begin
    instr_d = if_instr;
    pc_d    = if_pc_plus4;
    valid_d = if_valid;
    if (flush) begin
      instr_d = 32'h0000_0000;
      pc_d    = 32'h0;
      valid_d = 1'b0;
    end else if (stall) begin
      instr_d = instr_q;
      pc_d    = pc_q;
      valid_d = valid_q;
    end
  end

  // IF/ID pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= 32'h0;
      pc_q    <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  // Register-file write port; independent of stall and flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_write) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  assign id_valid    = valid_q;
  assign id_pc_plus4 = pc_q;
  assign id_opcode   = instr_q[31:26];
  assign id_rs       = instr_q[25:21];
  assign id_rt       = instr_q[20:16];
  assign id_rd       = instr_q[15:11];
  assign id_shamt    = instr_q[10:6];
  assign id_funct    = instr_q[5:0];
  assign id_imm16    = instr_q[15:0];
  assign id_jtarget  = instr_q[25:0];

  // rs read port: zero for r0, same-cycle write-back wins over the array.
  always_comb begin
    id_rs_data = '0;
    if (id_rs != 5'd0 && int'(id_rs) < NREGS) begin
      if (wb_write && wb_addr == id_rs) id_rs_data = wb_data;
      else                              id_rs_data = rf_q[id_rs];
    end
  end

  // rt read port: bypassed independently of rs.
  always_comb begin
    id_rt_data = '0;
    if (id_rt != 5'd0 && int'(id_rt) < NREGS) begin
      if (wb_write && wb_addr == id_rt) id_rt_data = wb_data;
      else                              id_rt_data = rf_q[id_rt];
    end
  end

endmodule
